// File: rtl/fp32_pkg.sv
// Shared single-precision definitions for the FP execution cluster:
// field widths, canonical encodings and operand classification.
package fp32_pkg;

   localparam int EXP_W  = 8;
   localparam int FRAC_W = 23;
   localparam int BIAS   = 127;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;
   localparam logic [31:0] PINF = 32'h7F80_0000;

   typedef enum logic [1:0] {
      ZERO   = 2'd0,
      NORMAL = 2'd1,
      INF    = 2'd2,
      NAN    = 2'd3
   } fp_class_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DIV  = 2'd1,
      S_NORM = 2'd2,
      S_DONE = 2'd3
   } div_state_e;

   // Denormals are flushed to zero on input, so exp==0 always classifies as ZERO.
   function automatic fp_class_e fp_classify(input logic [31:0] x);
      fp_class_e c;
      if (x[30:23] == 8'h00) begin
         c = ZERO;
      end else if (x[30:23] == 8'hFF) begin
         if (x[22:0] == 23'd0) begin
            c = INF;
         end else begin
            c = NAN;
         end
      end else begin
         c = NORMAL;
      end
      return c;
   endfunction

endpackage

// File: rtl/fp32_div_special.sv
// Special-operand resolution for the divider: decides from the operand
// classes whether the quotient is fixed without iterating, and what it is.
module fp32_div_special
   import fp32_pkg::*;
(
   input  logic [1:0]  cls_a_i,
   input  logic [1:0]  cls_b_i,
   input  logic        sign_i,
   output logic        is_special_o,
   output logic [31:0] result_o,
   output logic        dz_o
);

   fp_class_e ca_s;
   fp_class_e cb_s;

   assign ca_s = fp_class_e'(cls_a_i);
   assign cb_s = fp_class_e'(cls_b_i);

   // Priority: invalid operations first, then infinities, then zeros.
   always_comb begin
      is_special_o = 1'b1;
      result_o     = QNAN;
      dz_o         = 1'b0;
      if ((ca_s == NAN) || (cb_s == NAN) ||
          ((ca_s == ZERO) && (cb_s == ZERO)) ||
          ((ca_s == INF) && (cb_s == INF))) begin
         result_o = QNAN;
      end else if (ca_s == INF) begin
         result_o = {sign_i, PINF[30:0]};
      end else if (cb_s == ZERO) begin
         result_o = {sign_i, PINF[30:0]};
         dz_o     = 1'b1;
      end else if ((ca_s == ZERO) || (cb_s == INF)) begin
         result_o = {sign_i, 31'd0};
      end else begin
         is_special_o = 1'b0;
      end
   end

endmodule

// File: rtl/fp32_div_iter.sv
// Iterative restoring FP32 divider: one quotient bit per cycle, truncating,
// single operation in flight with valid/ready on both sides and flush.
module fp32_div_iter
   import fp32_pkg::*;
#(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_dz
);

   div_state_e        state_q, state_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [24:0]       rem_q, rem_d;
   logic [23:0]       div_q, div_d;
   logic [24:0]       quo_q, quo_d;
   logic signed [9:0] exp_q, exp_d;
   logic              sign_q, sign_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic [31:0]       res_q, res_d;
   logic              dz_q, dz_d;

   logic              sp_is_s;
   logic [31:0]       sp_res_s;
   logic              sp_dz_s;
   logic [1:0]        cls_a_s;
   logic [1:0]        cls_b_s;
   logic              in_sign_s;
   logic [24:0]       sub_s;
   logic              ge_s;
   logic signed [9:0] exp_n_s;
   logic [22:0]       frac_n_s;

   assign cls_a_s   = fp_classify(in_a);
   assign cls_b_s   = fp_classify(in_b);
   assign in_sign_s = in_a[31] ^ in_b[31];

   fp32_div_special u_special (
      .cls_a_i      (cls_a_s),
      .cls_b_i      (cls_b_s),
      .sign_i       (in_sign_s),
      .is_special_o (sp_is_s),
      .result_o     (sp_res_s),
      .dz_o         (sp_dz_s)
   );

   assign sub_s = rem_q - {1'b0, div_q};
   assign ge_s  = (rem_q >= {1'b0, div_q});

   // Quotient is in [0.5, 2): a clear top bit means one extra left shift.
   always_comb begin
      exp_n_s  = exp_q;
      frac_n_s = quo_q[23:1];
      if (quo_q[24]) begin
         exp_n_s  = exp_q;
         frac_n_s = quo_q[23:1];
      end else begin
         exp_n_s  = exp_q - 10'sd1;
         frac_n_s = quo_q[22:0];
      end
   end

   // Next-state and datapath update; flush has the last word.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      div_d   = div_q;
      quo_d   = quo_q;
      exp_d   = exp_q;
      sign_d  = sign_q;
      tag_d   = tag_q;
      res_d   = res_q;
      dz_d    = dz_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               tag_d  = in_tag;
               sign_d = in_sign_s;
               if (sp_is_s) begin
                  res_d   = sp_res_s;
                  dz_d    = sp_dz_s;
                  state_d = S_DONE;
               end else begin
                  rem_d   = {2'b01, in_a[22:0]};
                  div_d   = {1'b1, in_b[22:0]};
                  quo_d   = 25'd0;
                  cnt_d   = 5'd24;
                  exp_d   = $signed({2'b00, in_a[30:23]}) - $signed({2'b00, in_b[30:23]})
                            + 10'sd127;
                  state_d = S_DIV;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_DIV: begin
            quo_d = {quo_q[23:0], ge_s};
            rem_d = ge_s ? {sub_s[23:0], 1'b0} : {rem_q[23:0], 1'b0};
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd0) begin
               state_d = S_NORM;
            end else begin
               state_d = S_DIV;
            end
         end
         S_NORM: begin
            dz_d    = 1'b0;
            state_d = S_DONE;
            if (exp_n_s >= 10'sd255) begin
               res_d = {sign_q, PINF[30:0]};
            end else if (exp_n_s <= 10'sd0) begin
               res_d = {sign_q, 31'd0};
            end else begin
               res_d = {sign_q, exp_n_s[7:0], frac_n_s};
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (flush) begin
         state_d = S_IDLE;
      end else begin
         state_d = state_d;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 5'd0;
         rem_q   <= 25'd0;
         div_q   <= 24'd0;
         quo_q   <= 25'd0;
         exp_q   <= 10'sd0;
         sign_q  <= 1'b0;
         tag_q   <= {TAG_W{1'b0}};
         res_q   <= 32'd0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         div_q   <= div_d;
         quo_q   <= quo_d;
         exp_q   <= exp_d;
         sign_q  <= sign_d;
         tag_q   <= tag_d;
         res_q   <= res_d;
         dz_q    <= dz_d;
      end
   end

   assign in_ready   = (state_q == S_IDLE);
   assign out_valid  = (state_q == S_DONE);
   assign out_result = res_q;
   assign out_tag    = tag_q;
   assign out_dz     = dz_q;

endmodule

// File: tb/tb_fp32_div_iter.sv
// Scoreboard bench for fp32_div_iter: expected results are computed from a
// long-division reference model when an op is driven and popped on output.
module tb_fp32_div_iter;

   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_a;
   logic [31:0]      in_b;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_result;
   logic [TAG_W-1:0] out_tag;
   logic             out_dz;

   typedef struct packed {
      logic [31:0]      res;
      logic [TAG_W-1:0] tag;
      logic             dz;
      logic             sp;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   fp32_div_iter #(.TAG_W(TAG_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_tag    (out_tag),
      .out_dz     (out_dz)
   );

   task automatic check_val(input string name, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, obs, expv);
      end
   endtask

   // Reference: exact integer quotient of the significands, then truncation.
   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic dz, output logic sp);
      logic [7:0]  ea, eb, e8;
      logic        anan, bnan, ainf, binf, az, bz, s;
      logic [63:0] q;
      logic [22:0] fr;
      int          e;
      ea   = a[30:23];
      eb   = b[30:23];
      az   = (ea == 8'h00);
      bz   = (eb == 8'h00);
      ainf = (ea == 8'hFF) && (a[22:0] == 23'd0);
      binf = (eb == 8'hFF) && (b[22:0] == 23'd0);
      anan = (ea == 8'hFF) && (a[22:0] != 23'd0);
      bnan = (eb == 8'hFF) && (b[22:0] != 23'd0);
      s    = a[31] ^ b[31];
      dz   = 1'b0;
      sp   = 1'b1;
      r    = 32'h7FC0_0000;
      if (anan || bnan || (az && bz) || (ainf && binf)) begin
         r = 32'h7FC0_0000;
      end else if (ainf) begin
         r = {s, 8'hFF, 23'd0};
      end else if (bz) begin
         r  = {s, 8'hFF, 23'd0};
         dz = 1'b1;
      end else if (az || binf) begin
         r = {s, 31'd0};
      end else begin
         sp = 1'b0;
         q  = ({40'd0, 1'b1, a[22:0]} << 24) / {40'd0, 1'b1, b[22:0]};
         e  = int'(ea) - int'(eb) + 127;
         if (q[24]) begin
            fr = q[23:1];
         end else begin
            fr = q[22:0];
            e  = e - 1;
         end
         e8 = e[7:0];
         if (e >= 255)    r = {s, 8'hFF, 23'd0};
         else if (e <= 0) r = {s, 31'd0};
         else             r = {s, e8, fr};
      end
   endfunction

   // Present one operation at a negedge; returns at the negedge after it is accepted.
   task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
      logic [31:0] r;
      logic        dz, sp;
      int          w;
      w = 0;
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      check_val("in_ready_before_op", {31'd0, in_ready}, 32'd1);
      model(a, b, r, dz, sp);
      sb_q.push_back('{res: r, tag: tag, dz: dz, sp: sp});
      in_a     = a;
      in_b     = b;
      in_tag   = tag;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      while (!out_valid && lat < 60) begin
         @(negedge clk);
         lat++;
      end
   endtask

   // Wait for the result, optionally stall the CDB, then handshake and compare.
   task automatic collect(input int hold);
      exp_t e;
      int   lat;
      if (sb_q.size() == 0) begin
         check_val("scoreboard_empty", 32'd0, 32'd1);
         return;
      end
      e = sb_q.pop_front();
      wait_result(lat);
      check_val("out_valid", {31'd0, out_valid}, 32'd1);
      check_val("latency", lat, e.sp ? 32'd0 : 32'd26);
      for (int i = 0; i < hold; i++) begin
         in_a     = 32'h4000_0000;
         in_b     = 32'h3F80_0000;
         in_tag   = 4'hF;
         in_valid = 1'b1;
         @(negedge clk);
         check_val("hold_valid", {31'd0, out_valid}, 32'd1);
         check_val("hold_in_ready", {31'd0, in_ready}, 32'd0);
         check_val("hold_result", out_result, e.res);
         check_val("hold_tag", {28'd0, out_tag}, {28'd0, e.tag});
      end
      in_valid = 1'b0;
      check_val("result", out_result, e.res);
      check_val("tag", {28'd0, out_tag}, {28'd0, e.tag});
      check_val("dz", {31'd0, out_dz}, {31'd0, e.dz});
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_val("post_hs_valid", {31'd0, out_valid}, 32'd0);
      check_val("post_hs_ready", {31'd0, in_ready}, 32'd1);
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag, input int hold);
      drive_op(a, b, tag);
      collect(hold);
   endtask

   initial begin
      int lat;
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_a      = 32'd0;
      in_b      = 32'd0;
      in_tag    = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_val("rst_result", out_result, 32'd0);
      check_val("rst_tag", {28'd0, out_tag}, 32'd0);
      check_val("rst_dz", {31'd0, out_dz}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(32'h4160_0000, 32'h4110_0000, 4'd3, 0);
      check_val("ref_14_9", 32'h3FC7_1C71, 32'h3FC7_1C71 ^ (out_tag == 4'd3 ? 32'd0 : 32'd1));
      run_op(32'hBF80_0000, 32'h4040_0000, 4'd5, 0);
      run_op(32'h40C0_0000, 32'h4000_0000, 4'd7, 0);
      run_op(32'h3F80_0000, 32'h0000_0000, 4'd1, 0);
      run_op(32'h0000_0000, 32'h0000_0000, 4'd2, 0);
      run_op(32'h3F80_0000, 32'h7F80_0000, 4'd4, 0);
      run_op(32'h7FC1_2345, 32'h3F80_0000, 4'd6, 0);
      run_op(32'hFF80_0000, 32'h4000_0000, 4'd8, 0);
      run_op(32'h7F00_0000, 32'h3E80_0000, 4'd9, 0);
      run_op(32'h0080_0000, 32'h4000_0000, 4'd10, 0);
      run_op(32'h4160_0000, 32'h4110_0000, 4'd11, 20);

      drive_op(32'h4160_0000, 32'h4110_0000, 4'd12);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      void'(sb_q.pop_front());
      check_val("flush_div_valid", {31'd0, out_valid}, 32'd0);
      check_val("flush_div_ready", {31'd0, in_ready}, 32'd1);

      drive_op(32'h4160_0000, 32'h4110_0000, 4'd13);
      wait_result(lat);
      check_val("pre_flush_done", {31'd0, out_valid}, 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      void'(sb_q.pop_front());
      check_val("flush_done_valid", {31'd0, out_valid}, 32'd0);
      check_val("flush_done_ready", {31'd0, in_ready}, 32'd1);

      in_a     = 32'h3F80_0000;
      in_b     = 32'h0000_0000;
      in_tag   = 4'd14;
      in_valid = 1'b1;
      flush    = 1'b1;
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      check_val("flush_blocks_accept_ready", {31'd0, in_ready}, 32'd1);
      check_val("flush_blocks_accept_valid", {31'd0, out_valid}, 32'd0);
      run_op(32'h40C0_0000, 32'h4000_0000, 4'd15, 0);

      drive_op(32'h4160_0000, 32'h4110_0000, 4'd2);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      void'(sb_q.pop_front());
      check_val("async_rst_valid", {31'd0, out_valid}, 32'd0);
      check_val("async_rst_ready", {31'd0, in_ready}, 32'd1);
      check_val("async_rst_tag", {28'd0, out_tag}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int k = 0; k < 24; k++) begin
         logic [31:0] ra, rb;
         ra = $urandom;
         rb = $urandom;
         if (k % 2 == 0) begin
            ra[30:23] = 8'(64 + $urandom_range(0, 127));
            rb[30:23] = 8'(64 + $urandom_range(0, 127));
         end
         run_op(ra, rb, 4'($urandom_range(0, 15)), k % 5);
      end

      repeat (3) @(negedge clk);
      check_val("idle_no_output", {31'd0, out_valid}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
